dot_product_accumulator: RTL and testbench

- Consumes the element stream from the input memory stage (mem1_output/mem2_output, data_valid, element_count, reading_done) and computes the unsigned dot product of vectors A and B.
- Two-stage pipeline: registered multiply, then accumulate.
- Reports one result per vector with completion and error flags.
- Feeds the result/output memory stage downstream.

---
 rtl/dot_product_pkg.sv | 22 ++
 rtl/dp_mult_stage.sv | 30 +++
 rtl/dot_product_accumulator.sv | 129 ++++++++++++
 tb/tb_dot_product_accumulator.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_pkg.sv
// Shared definitions for the dot-product datapath: FSM states, default
// geometry and the accumulator width derivation.
package dot_product_pkg;

   localparam int DEF_DATA_WIDTH   = 8;
   localparam int DEF_VECTOR_WIDTH = 4;
   localparam int DEF_CNT_WIDTH    = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Full-width product plus enough headroom that summing vector_width
   // maximal products can never wrap.
   function automatic int acc_width(input int data_width, input int vector_width);
      return 2 * data_width + $clog2(vector_width);
   endfunction

endpackage

// File: rtl/dp_mult_stage.sv
// Registered unsigned multiplier: the first pipeline stage of the dot product.
// pv_q marks prod_q as holding a product that still has to be accumulated.
module dp_mult_stage
   import dot_product_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [DATA_WIDTH-1:0]   a,
   input  logic [DATA_WIDTH-1:0]   b,
   output logic [2*DATA_WIDTH-1:0] prod_q,
   output logic                    pv_q
);

   // Capture a*b on accepted elements; the valid bit follows en every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         prod_q <= '0;
         pv_q   <= 1'b0;
      end else begin
         pv_q <= en;
         if (en) begin
            prod_q <= {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
         end
      end
   end

endmodule

// File: rtl/dot_product_accumulator.sv
// Unsigned dot product of the A/B element stream: multiply stage, then
// accumulate, one result per vector with short-vector and sequence flags.
//
// Input handshake: in_valid qualifies a_in/b_in/in_index for one cycle and
// there is no backpressure. Elements are taken only in ACCUM; anything
// presented in IDLE, DRAIN or DONE is dropped. start is taken only in IDLE.
module dot_product_accumulator
   import dot_product_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int VECTOR_WIDTH = DEF_VECTOR_WIDTH,
   parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
   parameter int ACC_WIDTH    = acc_width(DATA_WIDTH, VECTOR_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] a_in,
   input  logic [DATA_WIDTH-1:0] b_in,
   input  logic [CNT_WIDTH-1:0]  in_index,
   input  logic                  in_done,
   output logic                  busy,
   output logic [ACC_WIDTH-1:0]  result,
   output logic                  result_valid,
   output logic                  short_err,
   output logic                  seq_err
);

   localparam int                   PROD_WIDTH = 2 * DATA_WIDTH;
   localparam logic [CNT_WIDTH-1:0] LAST_IDX   = CNT_WIDTH'(VECTOR_WIDTH - 1);

   state_t                state, state_d;
   logic                  accept;
   logic                  seq_hit;
   logic                  short_hit;
   logic                  drain_done;
   logic [CNT_WIDTH-1:0]  count;
   logic [ACC_WIDTH-1:0]  acc;
   logic [PROD_WIDTH-1:0] prod_q;
   logic                  pv_q;

   dp_mult_stage #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mult (
      .clk    (clk),
      .rst    (rst),
      .en     (accept),
      .a      (a_in),
      .b      (b_in),
      .prod_q (prod_q),
      .pv_q   (pv_q)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   // Next state and per-cycle control. DRAIN holds until the product stage
   // is empty so the result is taken from a fully settled accumulator.
   always_comb begin
      state_d    = state;
      accept     = 1'b0;
      seq_hit    = 1'b0;
      short_hit  = 1'b0;
      drain_done = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_d = ACCUM;
         end
         ACCUM: begin
            accept  = in_valid;
            seq_hit = in_valid && (in_index != count);
            if (in_valid && (count == LAST_IDX)) begin
               state_d = DRAIN;
            end else if (in_done) begin
               // The element (if any) is counted first; fewer than
               // VECTOR_WIDTH elements remain seen, so the vector is short.
               short_hit = 1'b1;
               state_d   = DRAIN;
            end
         end
         DRAIN: begin
            if (!pv_q) begin
               drain_done = 1'b1;
               state_d    = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Counter, accumulator, result and sticky flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         count        <= '0;
         acc          <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
         short_err    <= 1'b0;
         seq_err      <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         if (state == IDLE && start) begin
            count     <= '0;
            acc       <= '0;
            short_err <= 1'b0;
            seq_err   <= 1'b0;
            busy      <= 1'b1;
         end
         if (accept)    count     <= count + CNT_WIDTH'(1);
         if (seq_hit)   seq_err   <= 1'b1;
         if (short_hit) short_err <= 1'b1;
         if (pv_q)      acc       <= acc + ACC_WIDTH'(prod_q);
         if (drain_done) begin
            result       <= acc;
            result_valid <= 1'b1;
            busy         <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator: expected results are queued
// when a vector is driven and checked when result_valid pulses.
module tb_dot_product_accumulator;
   import dot_product_pkg::*;

   localparam int DW = DEF_DATA_WIDTH;
   localparam int VW = DEF_VECTOR_WIDTH;
   localparam int CW = DEF_CNT_WIDTH;
   localparam int AW = acc_width(DW, VW);
   localparam int EW = AW + 2;   // {short_err, seq_err, result}

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          in_valid;
   logic [DW-1:0] a_in;
   logic [DW-1:0] b_in;
   logic [CW-1:0] in_index;
   logic          in_done;
   logic          busy;
   logic [AW-1:0] result;
   logic          result_valid;
   logic          short_err;
   logic          seq_err;

   int tests  = 0;
   int fails  = 0;
   int pulses = 0;
   int pushes = 0;
   logic [EW-1:0]    exp_q[$];
   logic [EW-1:0]    mon_e;
   logic [VW*DW-1:0] pa, pb;
   logic [VW*CW-1:0] pi;

   // Clock and global time limit.
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   dot_product_accumulator dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .in_valid     (in_valid),
      .a_in         (a_in),
      .b_in         (b_in),
      .in_index     (in_index),
      .in_done      (in_done),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid),
      .short_err    (short_err),
      .seq_err      (seq_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every result_valid pulse consumes one expected entry.
   always @(negedge clk) begin
      if (result_valid === 1'b1) begin
         pulses++;
         check("queue_nonempty_on_result", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("result", 32'(result), 32'(mon_e[AW-1:0]));
            check("short_err", 32'(short_err), 32'(mon_e[AW+1]));
            check("seq_err", 32'(seq_err), 32'(mon_e[AW]));
         end
      end
   end

   // Driver tasks: inputs change on the falling edge, one cycle per call.
   task automatic drive(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [CW-1:0] idx, input logic done);
      @(negedge clk);
      in_valid = v;
      a_in     = a;
      b_in     = b;
      in_index = idx;
      in_done  = done;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, '0, 1'b0);
   endtask

   task automatic do_start();
      @(negedge clk);
      start    = 1'b1;
      in_valid = 1'b0;
      in_done  = 1'b0;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic push_exp(input logic short_f, input logic seq_f, input logic [AW-1:0] res);
      exp_q.push_back({short_f, seq_f, res});
      pushes++;
   endtask

   // Idle until result_valid; exp_lat > 0 also checks falling edges counted
   // after the last driven cycle.
   task automatic wait_result(input int exp_lat);
      int n;
      n = 0;
      do begin
         idle();
         n++;
      end while (result_valid !== 1'b1 && n < 20);
      check("result_valid_seen", 32'(result_valid), 1);
      if (exp_lat > 0) check("latency", n, exp_lat);
      idle();
      check("result_valid_single", 32'(result_valid), 0);
      check("busy_after_result", 32'(busy), 0);
   endtask

   task automatic run_vector(input logic [AW-1:0] exp_res, input logic exp_seq,
                             input int max_gap, input int exp_lat);
      int g;
      push_exp(1'b0, exp_seq, exp_res);
      do_start();
      check("flags_clear_on_start", 32'({short_err, seq_err}), 0);
      check("busy_on_start", 32'(busy), 1);
      for (int i = 0; i < VW; i++) begin
         drive(1'b1, pa[i*DW +: DW], pb[i*DW +: DW], pi[i*CW +: CW], 1'b0);
         if (max_gap > 0 && i < VW - 1) begin
            g = $urandom_range(max_gap, 1);
            repeat (g) begin
               idle();
               check("busy_in_gap", 32'(busy), 1);
            end
         end
      end
      wait_result(exp_lat);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_done = 1'b0;
      a_in = '0; b_in = '0; in_index = '0;
      pi = {3'd3, 3'd2, 3'd1, 3'd0};

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_result", 32'(result), 0);
      check("rst_result_valid", 32'(result_valid), 0);
      check("rst_flags", 32'({short_err, seq_err}), 0);
      rst = 1'b0;
      idle();

      // [1,2,3,4].[5,6,7,8] = 5+12+21+32 = 70, contiguous.
      pa = {8'd4, 8'd3, 8'd2, 8'd1};
      pb = {8'd8, 8'd7, 8'd6, 8'd5};
      run_vector(18'd70, 1'b0, 0, 3);

      // All-ones: 4*255*255 = 260100, must not wrap; then zeros after restart.
      pa = {4{8'hFF}};
      pb = {4{8'hFF}};
      run_vector(18'd260100, 1'b0, 0, 3);
      pa = '0;
      pb = '0;
      run_vector(18'd0, 1'b0, 0, 3);

      // Gapped stream: 1280+3072+5376+8192 = 17920.
      pa = {8'h40, 8'h30, 8'h20, 8'h10};
      pb = {8'h80, 8'h70, 8'h60, 8'h50};
      run_vector(18'd17920, 1'b0, 2, 3);

      // Short vector: two elements then in_done -> 5+12 = 17, short_err.
      pa = {8'd4, 8'd3, 8'd2, 8'd1};
      pb = {8'd8, 8'd7, 8'd6, 8'd5};
      push_exp(1'b1, 1'b0, 18'd17);
      do_start();
      drive(1'b1, 8'd1, 8'd5, 3'd0, 1'b0);
      drive(1'b1, 8'd2, 8'd6, 3'd1, 1'b0);
      drive(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
      wait_result(2);
      check("short_err_sticky", 32'(short_err), 1);

      // Index sequence 0,2,2,3: still accumulated, seq_err set.
      pi = {3'd3, 3'd2, 3'd2, 3'd0};
      run_vector(18'd70, 1'b1, 0, 3);
      check("seq_err_sticky", 32'(seq_err), 1);
      pi = {3'd3, 3'd2, 3'd1, 3'd0};
      run_vector(18'd70, 1'b0, 0, 3);

      // Reset mid-vector discards progress with no result pulse.
      do_start();
      drive(1'b1, 8'd1, 8'd5, 3'd0, 1'b0);
      drive(1'b1, 8'd2, 8'd6, 3'd1, 1'b0);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", 32'(busy), 0);
      check("midrst_result", 32'(result), 0);
      check("midrst_flags", 32'({result_valid, short_err, seq_err}), 0);
      begin
         int p;
         p = pulses;
         repeat (5) idle();
         check("midrst_no_pulse", pulses, p);
      end

      // Full vector with a stray start in ACCUM and a fifth element after
      // the fourth; both are ignored.
      push_exp(1'b0, 1'b0, 18'd70);
      do_start();
      drive(1'b1, 8'd1, 8'd5, 3'd0, 1'b0);
      do_start();
      check("busy_after_stray_start", 32'(busy), 1);
      drive(1'b1, 8'd2, 8'd6, 3'd1, 1'b0);
      drive(1'b1, 8'd3, 8'd7, 3'd2, 1'b0);
      drive(1'b1, 8'd4, 8'd8, 3'd3, 1'b0);
      drive(1'b1, 8'd9, 8'd9, 3'd4, 1'b0);
      wait_result(-1);

      repeat (3) idle();
      check("queue_drained", exp_q.size(), 0);
      check("pulse_count", pulses, pushes);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
